// File: rtl/fb_rect_writer_if.sv
// Command, pixel-stream and BRAM port-B write bundle for fb_rect_writer.
// The master side issues commands and pixels; the slave side writes the frame buffer.
interface fb_rect_writer_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 12
) ();
  logic              start;
  logic [9:0]        x0;
  logic [9:0]        y0;
  logic [9:0]        w;
  logic [9:0]        h;
  logic              busy;
  logic              done;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;

  modport master (
    output start, x0, y0, w, h, pix_valid, pix_data,
    input  busy, done, pix_ready, wea, addra, dina
  );

  modport slave (
    input  start, x0, y0, w, h, pix_valid, pix_data,
    output busy, done, pix_ready, wea, addra, dina
  );
endinterface

// File: rtl/fb_rect_writer.sv
// Rectangle blitter into the linearly scanned RGB444 frame buffer: clips off-screen pixels,
// skips the transparent key colour, and issues registered BRAM port-B writes.
module fb_rect_writer #(
  parameter int unsigned        H_RES     = 800,
  parameter int unsigned        V_RES     = 600,
  parameter int unsigned        ADDR_W    = 19,
  parameter int unsigned        DATA_W    = 12,
  parameter logic [DATA_W-1:0]  KEY_COLOR = 12'hF0F
) (
  input logic             clk,
  input logic             rst_n,
  fb_rect_writer_if.slave bus
);

  localparam int unsigned RbW = ADDR_W + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [9:0]        x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [9:0]        cx_q, cx_d, cy_q, cy_d;
  logic [RbW-1:0]    row_base_q, row_base_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;

  logic hs, on_screen, last_col, last_row;

  assign hs        = bus.pix_valid && (state_q == StBusy);
  // 11-bit sums so that a rectangle hanging off the right/bottom edge never wraps back on
  assign on_screen = ((11'(x0_q) + 11'(cx_q)) < 11'(H_RES)) &&
                     ((11'(y0_q) + 11'(cy_q)) < 11'(V_RES));
  assign last_col  = (cx_q == w_q - 10'd1);
  assign last_row  = (cy_q == h_q - 10'd1);

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    row_base_d = row_base_q;
    wea_d      = 1'b0;
    addra_d    = addra_q;
    dina_d     = dina_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if ((bus.w != 10'd0) && (bus.h != 10'd0)) begin
            x0_d       = bus.x0;
            y0_d       = bus.y0;
            w_d        = bus.w;
            h_d        = bus.h;
            cx_d       = 10'd0;
            cy_d       = 10'd0;
            row_base_d = RbW'(bus.y0) * RbW'(H_RES) + RbW'(bus.x0);
            state_d    = StBusy;
          end else begin
            state_d = StDone;
          end
        end
      end
      StBusy: begin
        if (hs) begin
          // Address/data only move on a real write, so clipped pixels never show a bad address
          if (on_screen && (bus.pix_data != KEY_COLOR)) begin
            wea_d   = 1'b1;
            addra_d = ADDR_W'(row_base_q + RbW'(cx_q));
            dina_d  = bus.pix_data;
          end
          if (last_col) begin
            cx_d       = 10'd0;
            cy_d       = cy_q + 10'd1;
            row_base_d = row_base_q + RbW'(H_RES);
            if (last_row) begin
              state_d = StDone;
            end
          end else begin
            cx_d = cx_q + 10'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      row_base_q <= '0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      row_base_q <= row_base_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.pix_ready = (state_q == StBusy);
  assign bus.wea       = wea_q;
  assign bus.addra     = addra_q;
  assign bus.dina      = dina_q;

endmodule
